imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writes the program image into instruction memory; the instruction memory is the read side, fetched by the core through its address-to-read-data port.
- Receives a little-endian byte stream over a valid/ready interface and assembles 32-bit words.
- Drives the instruction memory write port.
- Holds the core in reset until the image is fully loaded.

Parameters:
WIDTH, 32, data/address width of memory write port (fixed at 32 for word assembly)
DEPTH_WORDS, 256, instruction memory capacity in words; larger images are rejected

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse begins a load session
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
mem_we  output  1  instruction memory write enable
mem_addr  output  WIDTH  byte address of write (word-aligned)
mem_wd  output  WIDTH  write data word
cpu_rst  output  1  reset to core; high until load completes
done  output  1  load completed successfully
err  output  1  load rejected (length > DEPTH_WORDS)
words_loaded  output  16  count of words written this session

Behaviour:
- Reset (async, rst=1), all outputs forced:
  - state IDLE, mem_we=0, mem_addr=0, mem_wd=0, in_ready=0.
  - cpu_rst=1, done=0, err=0, words_loaded=0, byte counter 0.
- Stream format:
  - LEN0 = count[7:0], LEN1 = count[15:8].
  - Then 4*count payload bytes, little-endian per word (first byte -> bits 7:0).
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0. start -> LEN0; clear words_loaded, done, err, byte counter.
- LEN0: in_ready=1. On transfer, latch count[7:0] -> LEN1.
- LEN1: in_ready=1. On transfer, latch count[15:8], then evaluate full count:
  - count==0 -> DONE
  - count>DEPTH_WORDS -> ERR
  - else -> DATA
- DATA: in_ready=1.
  - Each transfer shifts the byte into assembly register lane byte_cnt; byte_cnt 0..3.
  - On the 4th transfer (byte_cnt==3) -> WRITE; byte_cnt wraps to 0.
- WRITE (exactly one cycle):
  - mem_we=1, mem_wd=assembled word, mem_addr=words_loaded*4, in_ready=0.
  - words_loaded increments at end of cycle.
  - If incremented words_loaded==count -> DONE, else -> DATA.
- DONE: done=1, cpu_rst=0, in_ready=0. Stays until start -> LEN0 (re-load: cpu_rst=1 again from the LEN0 cycle).
- ERR: err=1, cpu_rst=1, in_ready=0. Stays until start -> LEN0.
- cpu_rst, done, err, in_ready and mem_we are decodes of the registered state; no combinational path from inputs.
- mem_addr/mem_wd are registered and hold their last values outside WRITE; they are don't-care when mem_we=0.
- start is ignored in LEN0, LEN1, DATA and WRITE; a load cannot be aborted except by rst.
- in_valid with in_ready=0 is not consumed; the source must hold the byte.
- Gaps in in_valid: state and partial word are held indefinitely.
- Throughput: minimum 5 cycles per word (4 transfer cycles + 1 WRITE).
- Latency: last payload byte accepted in cycle T -> mem_we in T+1 -> done=1/cpu_rst=0 in T+2.
- Address arithmetic: mem_addr = {words_loaded, 2'b00}, zero-extended to WIDTH; never exceeds 4*(DEPTH_WORDS-1).
- rst mid-load: immediate return to reset values. Already-written memory words are not cleared; the core stays held in reset.

Decomposition:
- Shared package: loader state enum (7 states, 3-bit) and constant for the header length of 2 bytes.
- One natural sub-module, byte_assembler: 4-lane shift/lane-write register with byte counter and word_ready flag. The top keeps the FSM, length check and address generation.

Test Plan:
- Reset -> cpu_rst=1, in_ready=0, mem_we=0, done=0, err=0, words_loaded=0 with no clock edge needed.
- Load 2 words: start, stream 02 00 13 05 A0 00 93 05 10 00.
  - mem_we pulses twice: addr 0x0 data 0x00A00513, then addr 0x4 data 0x00100593.
  - done=1 and cpu_rst=0 two cycles after the last byte; words_loaded=2.
- Zero length: start, stream 00 00 -> DONE directly, no mem_we, cpu_rst=0.
- Oversize: stream 01 01 (257 words, DEPTH_WORDS=256) -> err=1, cpu_rst=1, in_ready=0, no writes.
- Backpressure/gaps:
  - Random in_valid gaps and in_valid held high during WRITE -> no byte lost or duplicated; word data identical to the gap-free run.
  - start pulsed mid-DATA is ignored.
- Reset mid-load: assert rst after 2 payload bytes of word 1.
  - Outputs return to reset values immediately.
  - A subsequent full 1-word load of DEADBEEF (bytes EF BE AD DE) writes 0xDEADBEEF at 0x0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction memory loader.
// Holds the loader state encoding and the stream header size.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Assembles little-endian bytes into a 32-bit word, one lane per byte.
// Ports: clk, rst, i_clr, i_shift, i_byte -> o_word_nxt, o_word_ready.
module imem_loader_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_nxt,
    output logic        o_word_ready
);
    import imem_loader_pkg::*;

    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic [31:0] w_nxt;

    // Word as it will look once the current byte lands in its lane.
    always_comb begin
        w_nxt = r_word;
        unique case (r_cnt)
            2'd0: w_nxt[7:0]   = i_byte;
            2'd1: w_nxt[15:8]  = i_byte;
            2'd2: w_nxt[23:16] = i_byte;
            2'd3: w_nxt[31:24] = i_byte;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= w_nxt;
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign o_word_nxt   = w_nxt;
    assign o_word_ready = i_shift && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core in reset.
// Ports: clk, rst, start, in_valid/in_data/in_ready, mem_we/addr/wd, cpu_rst, done, err, words_loaded.
module imem_loader #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    output logic             cpu_rst,
    output logic             done,
    output logic             err,
    output logic [15:0]      words_loaded
);
    import imem_loader_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_count;
    logic [15:0]      r_words;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wd;

    logic        w_xfer;
    logic        w_start_ok;
    logic        w_shift;
    logic        w_word_ready;
    logic [31:0] w_word_nxt;
    logic [15:0] w_len;
    logic [15:0] w_words_inc;

    assign w_xfer      = in_valid && in_ready;
    assign w_len       = {in_data, r_count[7:0]};
    assign w_words_inc = r_words + 16'd1;
    assign w_shift     = w_xfer && (r_state == S_DATA);
    assign w_start_ok  = start && (r_state == S_IDLE ||
                                   r_state == S_DONE ||
                                   r_state == S_ERR);

    imem_loader_byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start_ok),
        .i_shift      (w_shift),
        .i_byte       (in_data),
        .o_word_nxt   (w_word_nxt),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        cpu_rst     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LEN0;
            end
            S_LEN0: begin
                in_ready = 1'b1;
                if (w_xfer) w_state_nxt = S_LEN1;
            end
            S_LEN1: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len == 16'd0)
                        w_state_nxt = S_DONE;
                    else if (w_len > 16'(DEPTH_WORDS))
                        w_state_nxt = S_ERR;
                    else
                        w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (w_word_ready) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (w_words_inc == r_count)
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = S_DATA;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) w_state_nxt = S_LEN0;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) w_state_nxt = S_LEN0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address and data are captured with the 4th byte so they are stable for the WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_words <= '0;
            r_addr  <= '0;
            r_wd    <= '0;
        end else begin
            if (w_start_ok) begin
                r_count <= '0;
                r_words <= '0;
            end
            if (r_state == S_LEN0 && w_xfer) r_count[7:0]  <= in_data;
            if (r_state == S_LEN1 && w_xfer) r_count[15:8] <= in_data;
            if (w_word_ready) begin
                r_wd   <= WIDTH'(w_word_nxt);
                r_addr <= WIDTH'({r_words, 2'b00});
            end
            if (r_state == S_WRITE) r_words <= w_words_inc;
        end
    end

    assign mem_addr     = r_addr;
    assign mem_wd       = r_wd;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Drives the byte stream at negedges and logs memory writes at negedges.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wd);
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            n_err++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({cpu_rst, in_ready, mem_we, done, err} !== 5'b10000) begin
            $display("FAIL %s_ctrl: got cpu_rst/rdy/we/done/err=%b required 10000",
                     tag, {cpu_rst, in_ready, mem_we, done, err});
            n_err++;
        end
        n_vec++;
        if (words_loaded !== 16'd0 || mem_addr !== 32'd0 || mem_wd !== 32'd0) begin
            $display("FAIL %s_regs: got wl=%0d addr=%h wd=%h required 0 0 0",
                     tag, words_loaded, mem_addr, mem_wd);
            n_err++;
        end
    endtask

    task automatic check_two_words(input string tag);
        n_vec++;
        if (q_addr.size() != 2) begin
            $display("FAIL %s_nwrites: got %0d required 2", tag, q_addr.size());
            n_err++;
        end else begin
            n_vec++;
            if (q_addr[0] !== 32'h0 || q_data[0] !== 32'h00A00513) begin
                $display("FAIL %s_w0: got %h@%h required 00a00513@00000000",
                         tag, q_data[0], q_addr[0]);
                n_err++;
            end
            n_vec++;
            if (q_addr[1] !== 32'h4 || q_data[1] !== 32'h00100593) begin
                $display("FAIL %s_w1: got %h@%h required 00100593@00000004",
                         tag, q_data[1], q_addr[1]);
                n_err++;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");
    endtask

    task automatic test_load2();
        logic [7:0] img [10];
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        q_addr.delete();
        q_data.delete();
        pulse_start();
        n_vec++;
        if (cpu_rst !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL load2_len0: got cpu_rst=%0b rdy=%0b required 1 1",
                     cpu_rst, in_ready);
            n_err++;
        end
        for (int i = 0; i < 10; i++) send(img[i]);
        n_vec++;
        if (mem_we !== 1'b1 || done !== 1'b0) begin
            $display("FAIL load2_t1: got we=%0b done=%0b required 1 0", mem_we, done);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 16'd2) begin
            $display("FAIL load2_t2: got done=%0b cpu_rst=%0b wl=%0d required 1 0 2",
                     done, cpu_rst, words_loaded);
            n_err++;
        end
        check_two_words("load2");
    endtask

    task automatic test_zero_len();
        q_addr.delete();
        q_data.delete();
        pulse_start();
        n_vec++;
        if (cpu_rst !== 1'b1) begin
            $display("FAIL zero_reload_rst: got cpu_rst=%0b required 1", cpu_rst);
            n_err++;
        end
        send(8'h00);
        send(8'h00);
        n_vec++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || q_addr.size() != 0) begin
            $display("FAIL zero_len: got done=%0b cpu_rst=%0b writes=%0d required 1 0 0",
                     done, cpu_rst, q_addr.size());
            n_err++;
        end
    endtask

    task automatic test_oversize();
        q_addr.delete();
        q_data.delete();
        pulse_start();
        send(8'h01);
        send(8'h01);
        @(negedge clk);
        n_vec++;
        if ({err, cpu_rst, in_ready, done} !== 4'b1100 || q_addr.size() != 0) begin
            $display("FAIL oversize: got err/cpu_rst/rdy/done=%b writes=%0d required 1100 0",
                     {err, cpu_rst, in_ready, done}, q_addr.size());
            n_err++;
        end
    endtask

    task automatic test_gaps();
        logic [7:0] img [10];
        int gap;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        q_addr.delete();
        q_data.delete();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            // byte after each word's last byte is presented during WRITE
            gap = (i == 6) ? 0 : (i * 7) % 3;
            repeat (gap) @(negedge clk);
            if (i == 4) begin
                pulse_start();
                n_vec++;
                if (in_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
                    $display("FAIL gaps_start_ignored: got rdy=%0b err=%0b done=%0b required 1 0 0",
                             in_ready, err, done);
                    n_err++;
                end
            end
            send(img[i]);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || words_loaded !== 16'd2) begin
            $display("FAIL gaps_done: got done=%0b wl=%0d required 1 2", done, words_loaded);
            n_err++;
        end
        check_two_words("gaps");
    endtask

    task automatic test_rst_mid();
        logic [7:0] img [6];
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        q_addr.delete();
        q_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send(img[i]);
        rst = 1'b1;
        #1;
        check_reset_outputs("rstmid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 6; i++) send(img[i]);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || q_addr.size() != 1) begin
            $display("FAIL rstmid_done: got done=%0b writes=%0d required 1 1",
                     done, q_addr.size());
            n_err++;
        end else begin
            n_vec++;
            if (q_addr[0] !== 32'h0 || q_data[0] !== 32'hDEADBEEF) begin
                $display("FAIL rstmid_word: got %h@%h required deadbeef@00000000",
                         q_data[0], q_addr[0]);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load2();
        test_zero_len();
        test_oversize();
        test_gaps();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
